// File: rtl/match_sequencer_if.sv
// Match sequencer bus: the per-frame/player event inputs and the game
// control/score outputs. The controller uses the slave modport; the
// surrounding datapath (or a bench) uses the master modport.
interface match_sequencer_if #(
  parameter int SCORE_W = 7
);
  // events into the sequencer
  logic               frame_tick;
  logic               start;
  logic               pause_req;
  logic               point_left;
  logic               point_right;
  // control and score out of the sequencer
  logic               game_reset;
  logic               ball_run;
  logic               racket_run;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_left;
  logic [SCORE_W-1:0] score_right;
  logic [1:0]         winner;
  logic [2:0]         state;

  modport master (
    output frame_tick, start, pause_req, point_left, point_right,
    input  game_reset, ball_run, racket_run, serve_dir,
           score_left, score_right, winner, state
  );

  modport slave (
    input  frame_tick, start, pause_req, point_left, point_right,
    output game_reset, ball_run, racket_run, serve_dir,
           score_left, score_right, winner, state
  );
endinterface

// File: rtl/match_sequencer.sv
// match_sequencer: pong match controller. Walks the game through
// idle -> serve countdown -> rally -> point hold -> (serve | game over),
// with a pause toggle during the rally. All outputs come straight from flops.
// Optional: define MATCH_DEUCE_EN to require a 2-point lead to win
// (saturated score still wins outright).
module match_sequencer #(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int SCORE_W      = 7
) (
  input  logic             clk,
  input  logic             reset,
  match_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_PAUSE = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  // one frame counter serves both countdowns, sized for the longer one
  localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W:0]   WIN_EXT    = (SCORE_W+1)'(WIN_SCORE);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_left_q, score_left_d;
  logic [SCORE_W-1:0] score_right_q, score_right_d;
  logic [1:0]         winner_q, winner_d;
  logic               serve_dir_q, serve_dir_d;
  logic               game_reset_q, game_reset_d;
  logic               ball_run_q, ball_run_d;
  logic               racket_run_q, racket_run_d;
  logic               start_prev_q, start_prev_d;

  logic               start_edge;
  logic [SCORE_W-1:0] scorer;
  logic               win_pt;

  assign start_edge = bus.start & ~start_prev_q;

  // Win check on the player who took the last point. serve_dir doubles as
  // "who scored": it points toward the loser, i.e. 1 after a left point.
`ifdef MATCH_DEUCE_EN
  logic [SCORE_W-1:0] opponent;
  always_comb begin
    scorer   = serve_dir_q ? score_left_q  : score_right_q;
    opponent = serve_dir_q ? score_right_q : score_left_q;
    win_pt   = (scorer == SCORE_MAX) ||
               (({1'b0, scorer} >= WIN_EXT) &&
                ({1'b0, scorer} >= ({1'b0, opponent} + (SCORE_W+1)'(2))));
  end
`else
  always_comb begin
    scorer = serve_dir_q ? score_left_q : score_right_q;
    win_pt = (scorer == SCORE_MAX) || ({1'b0, scorer} >= WIN_EXT);
  end
`endif

  // Next-state, counter, score and registered-output computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    winner_d      = winner_q;
    serve_dir_d   = serve_dir_q;
    game_reset_d  = 1'b0;
    start_prev_d  = bus.start;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          score_left_d  = '0;
          score_right_d = '0;
          winner_d      = 2'b00;
          serve_dir_d   = 1'b1;
          cnt_d         = SERVE_LOAD;
          state_d       = ST_SERVE;
          game_reset_d  = 1'b1;
        end
      end
      ST_SERVE: begin
        if (bus.frame_tick) begin
          if (cnt_q == '0) state_d = ST_PLAY;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_PLAY: begin
        // left point beats right point, any point beats pause
        if (bus.point_left) begin
          score_left_d = (score_left_q == SCORE_MAX) ? score_left_q : score_left_q + 1'b1;
          serve_dir_d  = 1'b1;
          cnt_d        = POINT_LOAD;
          state_d      = ST_POINT;
        end else if (bus.point_right) begin
          score_right_d = (score_right_q == SCORE_MAX) ? score_right_q : score_right_q + 1'b1;
          serve_dir_d   = 1'b0;
          cnt_d         = POINT_LOAD;
          state_d       = ST_POINT;
        end else if (bus.pause_req) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (bus.pause_req) state_d = ST_PLAY;
      end
      ST_POINT: begin
        if (bus.frame_tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (win_pt) begin
            winner_d = serve_dir_q ? 2'b01 : 2'b10;
            state_d  = ST_OVER;
          end else begin
            cnt_d        = SERVE_LOAD;
            state_d      = ST_SERVE;
            game_reset_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // run enables follow the state being entered so they line up with it
    ball_run_d   = (state_d == ST_PLAY);
    racket_run_d = (state_d == ST_PLAY) || (state_d == ST_SERVE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      score_left_q  <= '0;
      score_right_q <= '0;
      winner_q      <= 2'b00;
      serve_dir_q   <= 1'b1;
      game_reset_q  <= 1'b0;
      ball_run_q    <= 1'b0;
      racket_run_q  <= 1'b0;
      start_prev_q  <= 1'b1;  // a button held through reset must be re-pressed
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      winner_q      <= winner_d;
      serve_dir_q   <= serve_dir_d;
      game_reset_q  <= game_reset_d;
      ball_run_q    <= ball_run_d;
      racket_run_q  <= racket_run_d;
      start_prev_q  <= start_prev_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.game_reset  = game_reset_q;
  assign bus.ball_run    = ball_run_q;
  assign bus.racket_run  = racket_run_q;
  assign bus.serve_dir   = serve_dir_q;
  assign bus.score_left  = score_left_q;
  assign bus.score_right = score_right_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: a directed vector table, a scoring sequence
// around the win/deuce boundary, then random traffic against a reference model.
module tb_match_sequencer;
  localparam int WIN  = 3;
  localparam int SF   = 2;
  localparam int PF   = 2;
  localparam int SW   = 7;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  match_sequencer_if #(.SCORE_W(SW)) bus ();

  match_sequencer #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF), .SCORE_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: game phase, frames still to wait, scores, winner.
  int m_state = 0, m_ticks = 0, m_sl = 0, m_sr = 0, m_win = 0;
  bit m_dir = 1, m_gr = 0, m_sd = 1;

  function automatic int sat_inc(input int s);
    return (s + 1 > SMAX) ? SMAX : s + 1;
  endfunction

  function automatic bit wins(input int me, input int opp);
    if (me == SMAX) return 1'b1;
`ifdef MATCH_DEUCE_EN
    return (me >= WIN) && (me - opp >= 2);
`else
    return (me >= WIN);
`endif
  endfunction

  task automatic model_step(input bit rst, st, ft, pz, pl, pr);
    bit pressed;
    m_gr = 0;
    if (rst) begin
      m_state = 0; m_ticks = 0; m_sl = 0; m_sr = 0; m_win = 0; m_dir = 1; m_sd = 1;
      return;
    end
    pressed = st && !m_sd;
    m_sd = st;
    if (m_state == 0 || m_state == 5) begin
      if (pressed) begin
        m_sl = 0; m_sr = 0; m_win = 0; m_dir = 1;
        m_ticks = SF; m_state = 1; m_gr = 1;
      end
    end else if (m_state == 1) begin
      if (ft) begin
        m_ticks--;
        if (m_ticks == 0) m_state = 2;
      end
    end else if (m_state == 2) begin
      if (pl || pr) begin
        if (pl) begin m_sl = sat_inc(m_sl); m_dir = 1; end
        else    begin m_sr = sat_inc(m_sr); m_dir = 0; end
        m_ticks = PF; m_state = 3;
      end else if (pz) m_state = 4;
    end else if (m_state == 4) begin
      if (pz) m_state = 2;
    end else if (m_state == 3) begin
      if (ft) begin
        m_ticks--;
        if (m_ticks == 0) begin
          if (m_dir ? wins(m_sl, m_sr) : wins(m_sr, m_sl)) begin
            m_win = m_dir ? 1 : 2; m_state = 5;
          end else begin
            m_ticks = SF; m_state = 1; m_gr = 1;
          end
        end
      end
    end
  endtask

  task automatic compare(input string tag, input int st, input bit gr, br, rr,
                         input int sl, sr, input bit dir, input int win);
    checks++;
    if (bus.state !== 3'(st) || bus.game_reset !== gr || bus.ball_run !== br ||
        bus.racket_run !== rr || bus.score_left !== SW'(sl) || bus.score_right !== SW'(sr) ||
        bus.serve_dir !== dir || bus.winner !== 2'(win)) begin
      errors++;
      $display("FAIL %s: got st=%0d gr=%0b br=%0b rr=%0b sl=%0d sr=%0d dir=%0b win=%0d; want st=%0d gr=%0b br=%0b rr=%0b sl=%0d sr=%0d dir=%0b win=%0d",
               tag, bus.state, bus.game_reset, bus.ball_run, bus.racket_run, bus.score_left,
               bus.score_right, bus.serve_dir, bus.winner, st, gr, br, rr, sl, sr, dir, win);
    end
  endtask

  // One clock: drive inputs, step model at the edge, compare just after.
  task automatic cyc(input bit rst, st, ft, pz, pl, pr, input string tag);
    reset = rst; bus.start = st; bus.frame_tick = ft;
    bus.pause_req = pz; bus.point_left = pl; bus.point_right = pr;
    @(posedge clk);
    model_step(rst, st, ft, pz, pl, pr);
    #1;
    compare(tag, m_state, m_gr, (m_state == 2), (m_state == 1 || m_state == 2),
            m_sl, m_sr, m_dir, m_win);
  endtask

  typedef struct {
    bit rst, st, ft, pz, pl, pr;
    int state; bit gr, br, rr; int sl, sr; bit dir; int win;
  } vec_t;
  vec_t tbl[$];

  task automatic v(input bit rst, st, ft, pz, pl, pr, input int state,
                   input bit gr, br, rr, input int sl, sr, input bit dir, input int win);
    vec_t r;
    r.rst = rst; r.st = st; r.ft = ft; r.pz = pz; r.pl = pl; r.pr = pr;
    r.state = state; r.gr = gr; r.br = br; r.rr = rr;
    r.sl = sl; r.sr = sr; r.dir = dir; r.win = win;
    tbl.push_back(r);
  endtask

  task automatic run_to_play();
    for (int k = 0; k < 20 && m_state != 2; k++) cyc(0, 1, 1, 0, 0, 0, "serve");
    checks++;
    if (bus.state !== 3'd2) begin
      errors++;
      $display("FAIL serve_timeout: state=%0d want 2", bus.state);
    end
  endtask

  task automatic score_pt(input bit left);
    run_to_play();
    cyc(0, 1, 0, 0, left, !left, "point");
    for (int k = 0; k < 20 && m_state == 3; k++) cyc(0, 1, 1, 0, 0, 0, "hold");
  endtask

  task automatic expect_sw(input string tag, input int st, input int win);
    checks++;
    if (bus.state !== 3'(st) || bus.winner !== 2'(win)) begin
      errors++;
      $display("FAIL %s: state=%0d winner=%0d want state=%0d winner=%0d",
               tag, bus.state, bus.winner, st, win);
    end
  endtask

  initial begin
    bus.start = 0; bus.frame_tick = 0; bus.pause_req = 0;
    bus.point_left = 0; bus.point_right = 0;

    //  rst st ft pz pl pr | st gr br rr sl sr dir win
    v(1,0,0,0,0,0, 0,0,0,0, 0,0,1,0);  // reset
    v(0,0,0,0,0,0, 0,0,0,0, 0,0,1,0);
    v(0,1,0,0,0,0, 1,1,0,1, 0,0,1,0);  // start edge
    v(0,1,0,0,0,0, 1,0,0,1, 0,0,1,0);
    v(0,1,1,0,0,0, 1,0,0,1, 0,0,1,0);
    v(0,1,1,0,0,0, 2,0,1,1, 0,0,1,0);  // 2nd tick -> play
    v(0,0,0,0,1,1, 3,0,0,0, 1,0,1,0);  // both points: left wins
    v(0,0,1,0,0,0, 3,0,0,0, 1,0,1,0);
    v(0,0,0,0,0,0, 3,0,0,0, 1,0,1,0);
    v(0,0,1,0,0,0, 1,1,0,1, 1,0,1,0);  // re-serve
    v(0,0,0,0,0,0, 1,0,0,1, 1,0,1,0);
    v(0,0,1,0,0,0, 1,0,0,1, 1,0,1,0);
    v(0,0,1,0,0,0, 2,0,1,1, 1,0,1,0);
    v(0,0,0,0,0,1, 3,0,0,0, 1,1,0,0);  // right point
    v(0,0,1,0,0,0, 3,0,0,0, 1,1,0,0);
    v(0,0,1,0,0,0, 1,1,0,1, 1,1,0,0);
    v(0,0,1,0,0,0, 1,0,0,1, 1,1,0,0);
    v(0,0,1,0,0,0, 2,0,1,1, 1,1,0,0);
    v(0,0,0,1,1,0, 3,0,0,0, 2,1,1,0);  // point beats pause
    v(0,0,1,0,0,0, 3,0,0,0, 2,1,1,0);
    v(0,0,1,0,0,0, 1,1,0,1, 2,1,1,0);
    v(0,0,1,0,0,0, 1,0,0,1, 2,1,1,0);
    v(0,0,1,0,0,0, 2,0,1,1, 2,1,1,0);
    v(0,0,0,1,0,0, 4,0,0,0, 2,1,1,0);  // pause
    v(0,0,1,0,0,0, 4,0,0,0, 2,1,1,0);
    v(0,0,1,0,1,0, 4,0,0,0, 2,1,1,0);
    v(0,0,1,0,0,1, 4,0,0,0, 2,1,1,0);
    v(0,0,1,0,0,0, 4,0,0,0, 2,1,1,0);
    v(0,0,1,0,0,0, 4,0,0,0, 2,1,1,0);
    v(0,0,0,1,0,0, 2,0,1,1, 2,1,1,0);  // resume
    v(0,0,0,0,1,0, 3,0,0,0, 3,1,1,0);
    v(0,0,1,0,0,0, 3,0,0,0, 3,1,1,0);
    v(0,0,1,0,0,0, 5,0,0,0, 3,1,1,1);  // game over, no game_reset
    v(0,0,0,0,0,0, 5,0,0,0, 3,1,1,1);
    v(0,0,0,0,1,0, 5,0,0,0, 3,1,1,1);
    v(0,1,0,0,0,0, 1,1,0,1, 0,0,1,0);  // restart clears
    v(0,1,0,1,0,0, 1,0,0,1, 0,0,1,0);
    v(1,1,0,0,0,0, 0,0,0,0, 0,0,1,0);  // mid-serve reset
    v(0,1,0,0,0,0, 0,0,0,0, 0,0,1,0);  // held start ignored
    v(0,0,0,0,0,0, 0,0,0,0, 0,0,1,0);
    v(0,1,0,0,0,0, 1,1,0,1, 0,0,1,0);
    v(0,1,0,0,0,1, 1,0,0,1, 0,0,1,0);  // point outside play
    v(0,1,1,0,0,0, 1,0,0,1, 0,0,1,0);
    v(0,1,1,0,0,0, 2,0,1,1, 0,0,1,0);
    v(1,1,0,0,0,0, 0,0,0,0, 0,0,1,0);  // reset in play

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].st, tbl[i].ft, tbl[i].pz, tbl[i].pl, tbl[i].pr,
          $sformatf("model_row%0d", i));
      compare($sformatf("table_row%0d", i), tbl[i].state, tbl[i].gr, tbl[i].br,
              tbl[i].rr, tbl[i].sl, tbl[i].sr, tbl[i].dir, tbl[i].win);
    end

    // Win boundary: 3-2 wins outright, or needs a 2-point lead with deuce.
    cyc(1, 0, 0, 0, 0, 0, "d_rst");
    cyc(0, 0, 0, 0, 0, 0, "d_idle");
    cyc(0, 1, 0, 0, 0, 0, "d_start");
    score_pt(1); score_pt(1); score_pt(0); score_pt(0); score_pt(1);
`ifdef MATCH_DEUCE_EN
    expect_sw("deuce_3_2", 1, 0);
    score_pt(0);
    expect_sw("deuce_3_3", 1, 0);
    score_pt(1);
    expect_sw("deuce_4_3", 1, 0);
    score_pt(1);
    expect_sw("deuce_5_3", 5, 1);
`else
    expect_sw("win_3_2", 5, 1);
`endif

    // Random traffic against the model.
    begin
      bit st = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(11) == 0) st = ~st;
        cyc($urandom_range(399) == 0, st, $urandom_range(2) == 0,
            $urandom_range(19) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0,
            $sformatf("rand%0d", i));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
